// File: rtl/pg_seq_pkg.sv
// pg_seq_pkg: state type, counter widths and parameter limits shared by the power-gate sequencer
package pg_seq_pkg;
    typedef enum logic [2:0] {
        S_OFF, S_WAKE_STEP, S_WAIT_OK, S_RELEASE, S_ON, S_ISOLATE, S_SLEEP_STEP, S_FAULT
    } pg_state_e;
    localparam int STEP_W = 8;
    localparam int TMO_W = 16;
    localparam int N_SEG_MIN = 2;
    localparam int N_SEG_MAX = 16;
    localparam int STEP_CYC_MIN = 1;
    localparam int STEP_CYC_MAX = 255;
    localparam int TMO_CYC_MIN = 1;
    localparam int TMO_CYC_MAX = 65535;
endpackage

// File: rtl/pg_seq_timer.sv
// pg_seq_timer: loadable down-counter that saturates at zero and flags terminal count
module pg_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign tc = cnt_q == '0;
endmodule

// File: rtl/pg_seq_ctrl.sv
// pg_seq_ctrl: staged header-switch power-up/down sequencer with isolation control and timeout fault
module pg_seq_ctrl import pg_seq_pkg::*; #(
    parameter int N_SEG    = 4,
    parameter int STEP_CYC = 8,
    parameter int TMO_CYC  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wake_req,
    input  logic             sleep_req,
    input  logic             vdd_ok,
    output logic [N_SEG-1:0] sw_en,
    output logic             iso_en,
    output logic             ready,
    output logic             fault
);
    localparam logic [STEP_W-1:0] STEP_LD = STEP_W'(STEP_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LD = TMO_W'(TMO_CYC - 1);
    pg_state_e state_q, state_d;
    logic [N_SEG-1:0] sw_q, sw_d, sw_up, sw_dn;
    logic iso_q, iso_d, ready_q, ready_d, fault_q, fault_d;
    logic step_tc, tmo_tc, step_ld, chg;
    logic [STEP_W-1:0] step_val;
    assign sw_up = {sw_q[N_SEG-2:0], 1'b1};
    assign sw_dn = sw_q >> 1;
    always_comb begin
        state_d = state_q;
        sw_d = sw_q;
        step_ld = 1'b0;
        case (state_q)
            S_OFF: if (wake_req) state_d = S_WAKE_STEP;
            S_WAKE_STEP:
                if (sleep_req) state_d = sw_q == '0 ? S_OFF : S_SLEEP_STEP;
                else if (step_tc) begin
                    step_ld = 1'b1;
                    if (&sw_q) state_d = S_WAIT_OK;
                    else sw_d = sw_up;
                end
            S_WAIT_OK:
                if (sleep_req) state_d = S_SLEEP_STEP;
                else if (vdd_ok) state_d = S_RELEASE;
                else if (tmo_tc) state_d = S_FAULT;
            S_RELEASE: state_d = S_ON;
            S_ON:
                if (sleep_req) state_d = S_ISOLATE;
                else if (!vdd_ok) state_d = S_WAIT_OK;
            S_ISOLATE: state_d = S_SLEEP_STEP;
            S_SLEEP_STEP:
                if (wake_req && !sleep_req) state_d = S_WAKE_STEP;
                else if (step_tc) begin
                    step_ld = 1'b1;
                    sw_d = sw_dn;
                    if (sw_dn == '0) state_d = S_OFF;
                end
            default: ;
        endcase
        if (state_d == S_FAULT) sw_d = '0;
    end
    assign iso_d = !(state_d == S_RELEASE || state_d == S_ON);
    assign ready_d = state_d == S_ON;
    assign fault_d = state_d == S_FAULT;
    // A state change reloads the step counter with 0 so the first step lands in the cycle after entry.
    assign chg = state_d != state_q;
    assign step_val = chg ? '0 : STEP_LD;
    pg_seq_timer #(.W(STEP_W)) u_step (
        .clk(clk), .rst(rst), .load(chg | step_ld), .load_val(step_val), .tc(step_tc)
    );
    pg_seq_timer #(.W(TMO_W)) u_tmo (
        .clk(clk), .rst(rst), .load(chg), .load_val(TMO_LD), .tc(tmo_tc)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_OFF;
            sw_q <= '0;
            iso_q <= 1'b1;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sw_q <= sw_d;
            iso_q <= iso_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    assign sw_en = sw_q;
    assign iso_en = iso_q;
    assign ready = ready_q;
    assign fault = fault_q;
endmodule

// File: tb/tb_pg_seq_ctrl.sv
// tb_pg_seq_ctrl: table-driven, hand-sequenced and randomized checks against a deadline-based model
module tb_pg_seq_ctrl;
    localparam int NS = 4;
    localparam int STEP = 8;
    localparam int TMO = 256;
    localparam int P_OFF = 0, P_WAKE = 1, P_WAIT = 2, P_REL = 3, P_ON = 4, P_ISO = 5, P_SLP = 6, P_FLT = 7;
    logic clk = 1'b0;
    logic rst, wake_req, sleep_req, vdd_ok;
    logic [NS-1:0] sw_en;
    logic iso_en, ready, fault;
    int passed = 0, total = 0;
    int t = 0, ph, n, due, dl;
    typedef struct {
        logic wake, sleep, vdd;
        int hold;
        logic [3:0] sw;
        logic iso, rdy, flt;
    } vec_t;
    vec_t vecs[$];

    pg_seq_ctrl #(.N_SEG(NS), .STEP_CYC(STEP), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .wake_req(wake_req), .sleep_req(sleep_req), .vdd_ok(vdd_ok),
        .sw_en(sw_en), .iso_en(iso_en), .ready(ready), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic w, s, v, input int h, input logic [3:0] sw, input logic iso, rdy, flt);
        vec_t r;
        r.wake = w; r.sleep = s; r.vdd = v; r.hold = h;
        r.sw = sw; r.iso = iso; r.rdy = rdy; r.flt = flt;
        vecs.push_back(r);
    endtask

    task automatic model_reset();
        ph = P_OFF;
        n = 0;
    endtask

    // Segment count plus absolute deadlines for the next step and for the vdd_ok timeout.
    task automatic model_step();
        t++;
        case (ph)
            P_OFF: if (wake_req) begin ph = P_WAKE; due = t + 1; end
            P_WAKE:
                if (sleep_req) begin ph = (n == 0) ? P_OFF : P_SLP; due = t + 1; end
                else if (t >= due) begin
                    if (n == NS) begin ph = P_WAIT; dl = t + TMO; end
                    else begin n++; due = t + STEP; end
                end
            P_WAIT:
                if (sleep_req) begin ph = P_SLP; due = t + 1; end
                else if (vdd_ok) ph = P_REL;
                else if (t >= dl) begin ph = P_FLT; n = 0; end
            P_REL: ph = P_ON;
            P_ON:
                if (sleep_req) ph = P_ISO;
                else if (!vdd_ok) begin ph = P_WAIT; dl = t + TMO; end
            P_ISO: begin ph = P_SLP; due = t + 1; end
            P_SLP:
                if (wake_req && !sleep_req) begin ph = P_WAKE; due = t + 1; end
                else if (t >= due) begin
                    n--;
                    due = t + STEP;
                    if (n == 0) ph = P_OFF;
                end
            default: ;
        endcase
    endtask

    function automatic logic [6:0] model_out();
        logic [3:0] sw;
        sw = 4'((1 << n) - 1);
        return {sw, !(ph == P_REL || ph == P_ON), ph == P_ON, ph == P_FLT};
    endfunction

    task automatic step_cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
            @(negedge clk);
            chk("model", {sw_en, iso_en, ready, fault}, model_out());
        end
    endtask

    initial begin
        rst = 1'b1; wake_req = 1'b0; sleep_req = 1'b0; vdd_ok = 1'b0;
        model_reset();
        add(1,0,0,  1, 4'd0, 1,0,0); add(0,0,0,  1, 4'd1, 1,0,0); add(0,0,0,  8, 4'd3, 1,0,0);
        add(0,0,0,  8, 4'd7, 1,0,0); add(0,0,0,  8, 4'd15,1,0,0); add(0,0,0,  8, 4'd15,1,0,0);
        add(0,0,0, 11, 4'd15,1,0,0); add(0,0,1,  1, 4'd15,0,0,0); add(0,0,1,  1, 4'd15,0,1,0);
        add(0,1,1,  1, 4'd15,1,0,0); add(0,0,1,  1, 4'd15,1,0,0); add(0,0,1,  1, 4'd7, 1,0,0);
        add(0,0,1,  8, 4'd3, 1,0,0); add(0,0,1,  8, 4'd1, 1,0,0); add(0,0,1,  8, 4'd0, 1,0,0);
        add(0,1,0,  5, 4'd0, 1,0,0); add(1,1,0,  1, 4'd0, 1,0,0); add(0,0,0,  1, 4'd1, 1,0,0);
        add(0,0,0,  8, 4'd3, 1,0,0); add(0,0,0,  8, 4'd7, 1,0,0); add(0,0,0,  8, 4'd15,1,0,0);
        add(0,0,0,  8, 4'd15,1,0,0); add(0,0,1,  2, 4'd15,0,1,0); add(1,1,1,  1, 4'd15,1,0,0);
        add(0,0,1,  1, 4'd15,1,0,0); add(0,0,1,  1, 4'd7, 1,0,0); add(0,0,1,  8, 4'd3, 1,0,0);
        add(1,0,1,  1, 4'd3, 1,0,0); add(0,0,1,  1, 4'd7, 1,0,0); add(0,0,1,  8, 4'd15,1,0,0);
        add(0,0,1,  8, 4'd15,1,0,0); add(0,0,1,  1, 4'd15,0,0,0); add(0,0,1,  1, 4'd15,0,1,0);
        add(0,0,0,  1, 4'd15,1,0,0); add(0,0,0,  2, 4'd15,1,0,0); add(0,0,1,  1, 4'd15,0,0,0);
        add(0,0,1,  1, 4'd15,0,1,0); add(0,0,0,  1, 4'd15,1,0,0); add(0,0,0,255, 4'd15,1,0,0);
        add(0,0,0,  1, 4'd0, 1,0,1); add(1,0,0, 10, 4'd0, 1,0,1);
        repeat (2) @(negedge clk);
        chk("reset sw_en", sw_en, 0);
        chk("reset iso_en", iso_en, 1);
        chk("reset ready", ready, 0);
        chk("reset fault", fault, 0);
        rst = 1'b0;
        foreach (vecs[i]) begin
            wake_req = vecs[i].wake; sleep_req = vecs[i].sleep; vdd_ok = vecs[i].vdd;
            step_cycles(vecs[i].hold);
            chk($sformatf("row%0d sw_en", i), sw_en, vecs[i].sw);
            chk($sformatf("row%0d iso_en", i), iso_en, vecs[i].iso);
            chk($sformatf("row%0d ready", i), ready, vecs[i].rdy);
            chk($sformatf("row%0d fault", i), fault, vecs[i].flt);
        end
        wake_req = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 chk("async rst fault", fault, 0);
        chk("async rst iso_en", iso_en, 1);
        @(negedge clk);
        rst = 1'b0;
        wake_req = 1'b1;
        step_cycles(1);
        wake_req = 1'b0;
        step_cycles(17);
        chk("mid-wake sw_en", sw_en, 7);
        #2 rst = 1'b1;
        model_reset();
        #1 chk("async rst sw_en", sw_en, 0);
        chk("async rst iso_en mid-wake", iso_en, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(599) == 0) begin
                rst = 1'b1;
                step_cycles(2);
                rst = 1'b0;
            end
            wake_req = $urandom_range(7) == 0;
            sleep_req = $urandom_range(39) == 0;
            if (vdd_ok ? ($urandom_range(39) == 0) : ($urandom_range(11) == 0)) vdd_ok = !vdd_ok;
            step_cycles(1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pg_seq_ctrl.md
PG_SEQ_CTRL -- requirements
Module: pg_seq_ctrl

Interface
REQ-001 Parameter: N_SEG, default 4; number of header-switch segments on the gated inverter VDD rail (2..16).
REQ-002 Parameter: STEP_CYC, default 8; clk cycles between consecutive segment enables or disables (1..255).
REQ-003 Parameter: TMO_CYC, default 256; maximum clk cycles to wait for vdd_ok after the last segment is enabled (1..65535).
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: wake_req  input  1  level request to power the gated rail.
REQ-007 Port: sleep_req  input  1  level request to power down the gated rail.
REQ-008 Port: vdd_ok  input  1  gated-rail-good flag from the rail comparator; already synchronous to clk.
REQ-009 Port: sw_en  output  N_SEG  header-switch enables; bit i drives segment i switch ctrl.
REQ-010 Port: iso_en  output  1  output isolation/clamp enable for the gated inverters.
REQ-011 Port: ready  output  1  rail up, isolation released.
REQ-012 Port: fault  output  1  sticky timeout flag.

Function
REQ-013 States: OFF, WAKE_STEP, WAIT_OK, RELEASE, ON, ISOLATE, SLEEP_STEP, FAULT.
REQ-014 OFF: sw_en=0, iso_en=1, ready=0. wake_req=1 -> WAKE_STEP; sleep_req is ignored.
REQ-015 WAKE_STEP: segments are enabled in order bit0 first, one per STEP_CYC cycles; bit0 is set in the cycle after entry. The state is left STEP_CYC cycles after bit N_SEG-1 is set, giving the sequence sw_en = 1, 3, 7, 15 for N_SEG=4.
REQ-016 WAIT_OK: vdd_ok=1 -> RELEASE. If vdd_ok stays 0 for TMO_CYC cycles -> FAULT.
REQ-017 RELEASE: iso_en is deasserted and, one cycle later, the state moves to ON. Deassertion of iso_en therefore precedes ready by exactly 1 cycle.
REQ-018 ON: ready=1, sw_en all ones, iso_en=0. sleep_req=1 -> ISOLATE.
REQ-019 ON, vdd_ok falls: ready drops in the next cycle and the state moves to WAIT_OK with iso_en=1 and the timeout counter restarted.
REQ-020 ISOLATE: ready=0, iso_en=1 in the first cycle, held for 1 cycle, then -> SLEEP_STEP.
REQ-021 SLEEP_STEP: segments are cleared in reverse order (bit N_SEG-1 first), one per STEP_CYC cycles. The state moves to OFF in the cycle sw_en reaches 0.
REQ-022 wake_req and sleep_req both 1 in ON or OFF: sleep has priority in ON; wake has priority in OFF.
REQ-023 wake_req during SLEEP_STEP: the sequence reverses without returning to OFF. The controller enters WAKE_STEP keeping the current sw_en and continues enabling from the lowest cleared bit.
REQ-024 sleep_req during WAKE_STEP or WAIT_OK: the controller goes to SLEEP_STEP from the current sw_en, with iso_en kept at 1.
REQ-025 FAULT: sw_en=0 immediately, iso_en=1, ready=0, fault=1. Only rst leaves FAULT; the requests are ignored.
REQ-026 The step counter is 8 bits and the timeout counter is 16 bits. Both reload on every state change and never wrap: they saturate at terminal count.
REQ-027 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-028 rst=1 forces asynchronously: state=OFF, sw_en=0, iso_en=1, ready=0, fault=0, counters=0.
REQ-029 rst asserted mid-sequence drops all switch enables in the same instant, with no staged ramp-down.
REQ-030 After rst deasserts, the first state transition occurs no earlier than the first rising clk edge.

Structure
REQ-031 Package pg_seq_pkg holds the state enum type, the counter-width constants (STEP_W=8, TMO_W=16) and the parameter range limits.
REQ-032 Sub-module pg_seq_timer: a loadable, saturating down-counter with a terminal-count output. It is instantiated twice, once for the step counter and once for the timeout counter.
REQ-033 The enables in sw_en drive the RC switch models through the existing xbit conversion; the conversion itself sits outside this block.

Verification
REQ-034 Wake: N_SEG=4, STEP_CYC=8, pulse wake_req, vdd_ok rises 20 cycles after sw_en=15 -> sw_en steps 1,3,7,15 at 8-cycle spacing; iso_en falls, then ready=1 one cycle later.
REQ-035 Timeout: TMO_CYC=256, vdd_ok held 0 -> fault=1 and sw_en=0 exactly 256 cycles after WAIT_OK entry; wake_req is then ignored until rst.
REQ-036 Sleep from ON: assert sleep_req -> ready=0 next cycle; sw_en goes 7,3,1,0 at 8-cycle spacing; final state is OFF.
REQ-037 Reversal: wake_req while sw_en=3 in SLEEP_STEP -> sw_en goes 7 then 15, with no visit to 0.
REQ-038 Async reset: rst raised mid-WAKE_STEP with sw_en=7 -> sw_en=0 and iso_en=1 before the next clk edge.
REQ-039 Brown-out: vdd_ok drops for 3 cycles while in ON -> ready=0, iso_en=1; on recovery, ready returns via RELEASE with fault=0.
